// File: rtl/glb_load_scheduler.sv
// -----------------------------------------------------------------------------
// glb_load_scheduler
//
// Purpose: sequences DRAM -> GLB loads for up to three tensor types (FILTER,
// BIAS, IFMAP). A start pulse latches a type mask and per-type word counts.
// Each pending type is then handled in fixed order: one DRAM read request,
// then a stream of beats written to GLB addresses 0..N-1, then a one-cycle
// gap. A one-cycle done pulse closes the sequence.
//
// Handshake semantics (every valid/ready pair here): a transfer happens on a
// rising core_clk edge where valid and ready are both 1. Once valid is raised,
// the producer holds valid and its payload stable until that transfer. Valid
// never depends combinationally on ready.
//
// Ports:
//   core_clk, reset                   clock, async active-high reset
//   start, load_mask, *_words         launch pulse + config (sampled in IDLE)
//   dram_req_valid/ready/type/words   DRAM read-request channel
//   dram_rvalid/rready/rdata          DRAM read-data stream
//   glb_wr_valid/ready/type/addr/data GLB write port (one-entry output reg)
//   busy, done                        status: busy outside IDLE, done pulse
//   dbg_state                         current FSM state encoding
// -----------------------------------------------------------------------------
module glb_load_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  core_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            load_mask,
  input  logic [ADDR_WIDTH-1:0] filter_words,
  input  logic [ADDR_WIDTH-1:0] bias_words,
  input  logic [ADDR_WIDTH-1:0] ifmap_words,
  output logic                  dram_req_valid,
  input  logic                  dram_req_ready,
  output logic [1:0]            dram_req_type,
  output logic [ADDR_WIDTH-1:0] dram_req_words,
  input  logic                  dram_rvalid,
  output logic                  dram_rready,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  output logic                  glb_wr_valid,
  input  logic                  glb_wr_ready,
  output logic [1:0]            glb_wr_type,
  output logic [ADDR_WIDTH-1:0] glb_wr_addr,
  output logic [DATA_WIDTH-1:0] glb_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  localparam logic [1:0] TYPE_FILTER = 2'd0;
  localparam logic [1:0] TYPE_BIAS   = 2'd1;
  localparam logic [1:0] TYPE_IFMAP  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_REQ    = 3'd2,
    ST_XFER   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_GAP    = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t                state;
  logic [2:0]            mask_q;
  logic [ADDR_WIDTH-1:0] filter_q;
  logic [ADDR_WIDTH-1:0] bias_q;
  logic [ADDR_WIDTH-1:0] ifmap_q;
  logic [ADDR_WIDTH-1:0] counter;

  logic [2:0]            nonzero;
  logic [2:0]            pending;
  logic                  any_pending;
  logic [1:0]            sel_type;
  logic [ADDR_WIDTH-1:0] sel_words;
  logic [2:0]            type_bit;
  logic [ADDR_WIDTH-1:0] cnt_next;
  logic                  beat;
  logic                  wr_hs;

  // A type with a zero word count is never pending; SELECT drops its mask
  // bit in the same cycle it picks the next real type.
  assign nonzero     = {(ifmap_q != '0), (bias_q != '0), (filter_q != '0)};
  assign pending     = mask_q & nonzero;
  assign any_pending = |pending;

  always_comb begin
    sel_type  = TYPE_IFMAP;
    sel_words = ifmap_q;
    if (pending[0]) begin
      sel_type  = TYPE_FILTER;
      sel_words = filter_q;
    end else if (pending[1]) begin
      sel_type  = TYPE_BIAS;
      sel_words = bias_q;
    end
  end

  // dram_req_type holds the type currently being transferred.
  assign type_bit = 3'b001 << dram_req_type;
  // Counter wraps naturally at ADDR_WIDTH bits, so a count of 2^W-1 works.
  assign cnt_next = counter + 1'b1;

  // Accept a beat only when the output register is empty or draining this
  // cycle, so a new beat can replace the drained entry without a bubble.
  assign dram_rready = (state == ST_XFER) && (!glb_wr_valid || glb_wr_ready);
  assign beat        = dram_rvalid && dram_rready;
  assign wr_hs       = glb_wr_valid && glb_wr_ready;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      mask_q         <= '0;
      filter_q       <= '0;
      bias_q         <= '0;
      ifmap_q        <= '0;
      counter        <= '0;
      dram_req_valid <= 1'b0;
      dram_req_type  <= '0;
      dram_req_words <= '0;
      glb_wr_valid   <= 1'b0;
      glb_wr_type    <= '0;
      glb_wr_addr    <= '0;
      glb_wr_data    <= '0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q   <= load_mask;
            filter_q <= filter_words;
            bias_q   <= bias_words;
            ifmap_q  <= ifmap_words;
            state    <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (any_pending) begin
            mask_q         <= pending;
            dram_req_type  <= sel_type;
            dram_req_words <= sel_words;
            dram_req_valid <= 1'b1;
            counter        <= '0;
            state          <= ST_REQ;
          end else begin
            mask_q <= '0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_REQ: begin
          if (dram_req_ready) begin
            dram_req_valid <= 1'b0;
            state          <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat) begin
            glb_wr_valid <= 1'b1;
            glb_wr_data  <= dram_rdata;
            glb_wr_addr  <= counter;
            glb_wr_type  <= dram_req_type;
            counter      <= cnt_next;
            if (cnt_next == dram_req_words) begin
              state <= ST_DRAIN;
            end
          end else if (wr_hs) begin
            glb_wr_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // The last beat always leaves glb_wr_valid set on entry here.
          if (glb_wr_ready) begin
            glb_wr_valid <= 1'b0;
            mask_q       <= mask_q & ~type_bit;
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          state <= ST_SELECT;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
